// File: rtl/buble_pkg.sv
// Shared helpers for the bubble-collapsing valid/ready chain:
// capacity and occupancy-counter width as functions of the chain shape.
package buble_pkg;

    // Beats the whole chain can hold: one per stage, two with skid registers.
    function automatic int cap(input int depth, input bit reg_rdy);
        return reg_rdy ? 2 * depth : depth;
    endfunction

    // Width wide enough to count 0..2*depth (covers both ready modes).
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/buble_stage.sv
// One valid/ready stage. REG_RDY=0 collapses bubbles through a combinational
// ready; REG_RDY=1 adds a skid register so the upstream ready is a flop.
module buble_stage
    import buble_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit REG_RDY = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             vld_in,
    output logic             rdy_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    input  logic             rdy_out,
    output logic [WIDTH-1:0] data_out
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    if (REG_RDY == 1'b0) begin : g_comb

        logic load;

        assign rdy_in = !vld_q || rdy_out;
        assign load   = vld_in && rdy_in;

        // NOTE: state flops use non-blocking assignments so every stage samples
        // its neighbour's pre-edge value; blocking here would race the chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (load) begin
                vld_q <= 1'b1;
            end else if (rdy_out) begin
                vld_q <= 1'b0;
            end
        end

        // NOTE: data registers carry no reset; only the valid bits qualify them,
        // so leaving data unreset keeps the reset tree to the control flops.
        always_ff @(posedge clk) begin
            if (load) begin
                data_q <= data_in;
            end
        end

    end else begin : g_skid

        logic             skid_vld;
        logic [WIDTH-1:0] skid_data;
        logic             accept;
        logic             to_skid;
        logic             from_skid;

        // Ready comes straight from a flop: no path from rdy_out to rdy_in.
        assign rdy_in    = !skid_vld;
        assign accept    = vld_in && !skid_vld;
        assign to_skid   = accept && vld_q && !rdy_out;
        assign from_skid = skid_vld && rdy_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q    <= 1'b0;
                skid_vld <= 1'b0;
            end else if (flush) begin
                vld_q    <= 1'b0;
                skid_vld <= 1'b0;
            end else begin
                if (to_skid) begin
                    skid_vld <= 1'b1;
                end else if (from_skid) begin
                    skid_vld <= 1'b0;
                end

                if (accept || from_skid) begin
                    vld_q <= 1'b1;
                end else if (rdy_out) begin
                    vld_q <= 1'b0;
                end
            end
        end

        // Main always holds the oldest beat; the skid refills it first.
        always_ff @(posedge clk) begin
            if (from_skid) begin
                data_q <= skid_data;
            end else if (accept && !to_skid) begin
                data_q <= data_in;
            end

            if (to_skid) begin
                skid_data <= data_in;
            end
        end

    end

    assign vld_out  = vld_q;
    assign data_out = data_q;

endmodule

// File: rtl/buble_chain.sv
// DEPTH-stage valid/ready pipeline with optional registered ready, synchronous
// flush and an occupancy counter for flow-control monitoring.
module buble_chain
    import buble_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter bit REG_RDY = 1'b0,
    parameter int CNT_W   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_a,
    input  logic             vld_a,
    output logic             rdy_a,
    output logic [WIDTH-1:0] data_b,
    output logic             vld_b,
    input  logic             rdy_b,
    output logic [CNT_W-1:0] level
);

    localparam int CAP = cap(DEPTH, REG_RDY);

    // Element i is the link into stage i; element DEPTH is the b side.
    logic             vld_c  [0:DEPTH];
    logic             rdy_c  [0:DEPTH];
    logic [WIDTH-1:0] data_c [0:DEPTH];

    logic push;
    logic pop;

    assign vld_c[0]     = vld_a;
    assign data_c[0]    = data_a;
    assign rdy_c[DEPTH] = rdy_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        buble_stage #(
            .WIDTH   (WIDTH),
            .REG_RDY (REG_RDY)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .vld_in   (vld_c[i]),
            .rdy_in   (rdy_c[i]),
            .data_in  (data_c[i]),
            .vld_out  (vld_c[i+1]),
            .rdy_out  (rdy_c[i+1]),
            .data_out (data_c[i+1])
        );
    end

    // Flush and reset both override the stage ready toward the producer.
    assign rdy_a  = rdy_c[0] && !flush && rst_n;
    assign vld_b  = vld_c[DEPTH];
    assign data_b = data_c[DEPTH];

    assign push = vld_a && rdy_a;
    assign pop  = vld_b && rdy_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

    a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
        int'(level) <= CAP);

endmodule

// File: tb/tb_buble_chain.sv
// Directed bench for buble_chain: one combinational-ready and one skid
// instance, driven from a single linear initial block.
module tb_buble_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;

    logic             flush0, vld_a0, rdy_a0, vld_b0, rdy_b0;
    logic [WIDTH-1:0] data_a0, data_b0;
    logic [CNT_W-1:0] level0;

    logic             flush1, vld_a1, rdy_a1, vld_b1, rdy_b1;
    logic [WIDTH-1:0] data_a1, data_b1;
    logic [CNT_W-1:0] level1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    buble_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REG_RDY(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0),
        .data_a(data_a0), .vld_a(vld_a0), .rdy_a(rdy_a0),
        .data_b(data_b0), .vld_b(vld_b0), .rdy_b(rdy_b0),
        .level(level0)
    );

    buble_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REG_RDY(1'b1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .data_a(data_a1), .vld_a(vld_a1), .rdy_a(rdy_a1),
        .data_b(data_b1), .vld_b(vld_b1), .rdy_b(rdy_b1),
        .level(level1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] gq[$];
        logic        pat [5];
        int          k;

        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst_n  = 1'b0;
        flush0 = 1'b0; vld_a0 = 1'b0; rdy_b0 = 1'b0; data_a0 = '0;
        flush1 = 1'b0; vld_a1 = 1'b0; rdy_b1 = 1'b0; data_a1 = '0;

        // Reset state
        #2;
        check("rst_vld0", vld_b0, 0);
        check("rst_lvl0", level0, 0);
        check("rst_rdy0", rdy_a0, 0);
        check("rst_vld1", vld_b1, 0);
        check("rst_rdy1", rdy_a1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy0", rdy_a0, 1);
        check("post_rst_rdy1", rdy_a1, 1);
        check("post_rst_lvl1", level1, 0);

        // Stream 1..16 back-to-back, first vld_b 3 edges after first accept
        rdy_b0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            vld_a0  = (c < 16);
            data_a0 = 32'(c + 1);
            #1 check("s_rdy", rdy_a0, 1);
            tick();
            check("s_vld", vld_b0, 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) check("s_data", data_b0, 32'(c - 2));
        end
        check("s_lvl", level0, 0);

        // Fill and stall, comb ready: 4 accepts then rdy_a drops
        vld_a0 = 1'b1; rdy_b0 = 1'b0; k = 0;
        for (int c = 0; c < 6; c++) begin
            data_a0 = 32'h50 + 32'(k);
            #1 check("f0_rdy", rdy_a0, 32'(c < 4));
            if (c < 4) k++;
            tick();
        end
        check("f0_lvl", level0, 4);

        // Full push+pop for 5 cycles: level stays 4, oldest beats leave
        for (int j = 0; j < 5; j++) begin
            data_a0 = 32'h54 + 32'(j);
            rdy_b0  = 1'b1;
            #1 check("pp_rdy", rdy_a0, 1);
            check("pp_vld", vld_b0, 1);
            check("pp_data", data_b0, 32'h50 + 32'(j));
            tick();
            check("pp_lvl", level0, 4);
        end
        vld_a0 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1 check("pp_drain_vld", vld_b0, 1);
            check("pp_drain_data", data_b0, 32'h55 + 32'(j));
            tick();
        end
        check("pp_empty_vld", vld_b0, 0);
        check("pp_empty_lvl", level0, 0);

        // Fill and stall, skid mode: 8 accepts then rdy_a drops
        vld_a1 = 1'b1; rdy_b1 = 1'b0; k = 0;
        for (int c = 0; c < 10; c++) begin
            data_a1 = 32'h70 + 32'(k);
            #1 check("f1_rdy", rdy_a1, 32'(c < 8));
            if (c < 8) k++;
            tick();
        end
        check("f1_lvl", level1, 8);
        vld_a1 = 1'b0;
        rdy_b1 = 1'b1;
        #1 check("f1_rdy_is_flop", rdy_a1, 0);
        for (int j = 0; j < 8; j++) begin
            #1 check("f1_drain_vld", vld_b1, 1);
            check("f1_drain_data", data_b1, 32'h70 + 32'(j));
            tick();
        end
        check("f1_empty_vld", vld_b1, 0);
        check("f1_empty_lvl", level1, 0);

        // Bubble collapse: alternate-cycle pushes, rdy_b pattern 0,1,1,0,1
        for (int c = 0; c < 10; c++) begin
            vld_a0  = (c % 2 == 0);
            data_a0 = 32'h40 + 32'(c / 2);
            rdy_b0  = pat[c % 5];
            #1 check("b_rdy", rdy_a0, 1);
            if (vld_b0 && rdy_b0) gq.push_back(data_b0);
            tick();
        end
        vld_a0 = 1'b0; rdy_b0 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1 if (vld_b0) gq.push_back(data_b0);
            tick();
        end
        check("b_cnt", 32'(gq.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check("b_data", gq[i], 32'h40 + 32'(i));
        end

        // Flush with level=3 while 0xAA is offered
        rdy_b0 = 1'b0; vld_a0 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            data_a0 = 32'h60 + 32'(c);
            tick();
        end
        check("fl_lvl_pre", level0, 3);
        flush0 = 1'b1; data_a0 = 32'hAA;
        #1 check("fl_rdy", rdy_a0, 0);
        tick();
        flush0 = 1'b0; vld_a0 = 1'b0;
        #1 check("fl_lvl", level0, 0);
        check("fl_vld", vld_b0, 0);
        rdy_b0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("fl_no_aa", vld_b0, 0);
        end

        // Asynchronous reset mid-stream with both chains holding beats
        rdy_b0 = 1'b0; rdy_b1 = 1'b0; vld_a0 = 1'b1; vld_a1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            data_a0 = 32'h90 + 32'(c);
            data_a1 = 32'hA0 + 32'(c);
            tick();
        end
        check("ar_lvl0_pre", level0, 4);
        vld_a0 = 1'b0; vld_a1 = 1'b0;
        #3 rst_n = 1'b0;
        #1 check("ar_vld0", vld_b0, 0);
        check("ar_lvl0", level0, 0);
        check("ar_vld1", vld_b1, 0);
        check("ar_lvl1", level1, 0);
        check("ar_rdy0", rdy_a0, 0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("ar_rdy0_rel", rdy_a0, 1);
        check("ar_rdy1_rel", rdy_a1, 1);
        check("ar_vld0_rel", vld_b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
